// File: rtl/adc_acq_controller.sv
// adc_acq_controller: sequences one ADC channel's acquisition. Arm starts a circular
// pre-trigger capture into the ADC data memory. A trigger starts a post-trigger word count.
// A 3-word event header is then pushed into the header FIFO, and the event counter advances.
module adc_acq_controller #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned MAX_WORDS = 4095
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              arm_i,
    input  logic              trig_i,
    input  logic              adc_valid_i,
    input  logic [31:0]       adc_data_i,
    input  logic [31:0]       buffer_size_i,
    input  logic [31:0]       post_trig_size_i,
    input  logic [31:0]       channel_num_i,
    input  logic [31:0]       initial_trig_num_i,
    input  logic              trig_num_we_i,
    input  logic              header_fifo_full_i,
    output logic [31:0]       current_trig_num_o,
    output logic              mem_wea_o,
    output logic [ADDR_W-1:0] mem_addra_o,
    output logic [31:0]       mem_dina_o,
    output logic              header_fifo_wr_en_o,
    output logic [31:0]       header_fifo_din_o,
    output logic              acq_busy_o,
    output logic              acq_done_o
);

    typedef enum logic [1:0] {StIdle, StArmed, StPost, StHeader} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [ADDR_W-1:0] fill_q;
    logic [ADDR_W-1:0] end_addr_q;
    logic [31:0]       pcnt_q;
    logic [31:0]       post_size_q;
    logic [31:0]       chan_q;
    logic [1:0]        hdr_idx_q;
    logic [31:0]       trig_num_q;
    logic              mem_wea_q;
    logic [ADDR_W-1:0] mem_addra_q;
    logic [31:0]       mem_dina_q;
    logic              acq_done_q;

    logic [ADDR_W-1:0] len_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [ADDR_W-1:0] fill_d;
    logic [31:0]       pcnt_d;
    logic              store;
    logic              hdr_go;
    logic [31:0]       hdr_word;

    // Effective ring length: clamp to MAX_WORDS, and treat zero as a single-word ring.
    always_comb begin
        if (buffer_size_i > 32'(MAX_WORDS)) begin
            len_d = ADDR_W'(MAX_WORDS);
        end else if (buffer_size_i == 32'd0) begin
            len_d = ADDR_W'(1);
        end else begin
            len_d = buffer_size_i[ADDR_W-1:0];
        end
    end

    // Ring pointer, saturating fill level and post-trigger count for the next stored word.
    always_comb begin
        wr_addr_d = (wr_addr_q == len_q - ADDR_W'(1)) ? '0 : wr_addr_q + ADDR_W'(1);
        fill_d    = (fill_q == len_q) ? fill_q : fill_q + ADDR_W'(1);
        pcnt_d    = pcnt_q + 32'd1;
        store     = adc_valid_i && ((state_q == StArmed) || (state_q == StPost));
        hdr_go    = (state_q == StHeader) && !header_fifo_full_i;
    end

    // Header word selected by the current header index.
    always_comb begin
        hdr_word = '0;
        unique case (hdr_idx_q)
            2'd0:    hdr_word = chan_q;
            2'd1:    hdr_word = trig_num_q;
            2'd2:    hdr_word = {8'h00, 12'(fill_q), 12'(end_addr_q)};
            default: hdr_word = '0;
        endcase
    end

    // Acquisition FSM, ring writer, header sequencer and event counter.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q     <= StIdle;
            len_q       <= ADDR_W'(1);
            wr_addr_q   <= '0;
            fill_q      <= '0;
            end_addr_q  <= '0;
            pcnt_q      <= '0;
            post_size_q <= '0;
            chan_q      <= '0;
            hdr_idx_q   <= '0;
            trig_num_q  <= '0;
            mem_wea_q   <= 1'b0;
            mem_addra_q <= '0;
            mem_dina_q  <= '0;
            acq_done_q  <= 1'b0;
        end else begin
            mem_wea_q  <= 1'b0;
            acq_done_q <= 1'b0;

            if (store) begin
                mem_wea_q   <= 1'b1;
                mem_addra_q <= wr_addr_q;
                mem_dina_q  <= adc_data_i;
                wr_addr_q   <= wr_addr_d;
                fill_q      <= fill_d;
                end_addr_q  <= wr_addr_q;
            end

            if (trig_num_we_i) begin
                trig_num_q <= initial_trig_num_i;
            end

            case (state_q)
                StIdle: begin
                    if (arm_i) begin
                        state_q    <= StArmed;
                        len_q      <= len_d;
                        wr_addr_q  <= '0;
                        fill_q     <= '0;
                        end_addr_q <= '0;
                    end
                end
                StArmed: begin
                    if (trig_i) begin
                        post_size_q <= post_trig_size_i;
                        chan_q      <= channel_num_i;
                        pcnt_q      <= '0;
                        hdr_idx_q   <= '0;
                        state_q     <= (post_trig_size_i == 32'd0) ? StHeader : StPost;
                    end
                end
                StPost: begin
                    if (adc_valid_i) begin
                        pcnt_q <= pcnt_d;
                        if (pcnt_d == post_size_q) begin
                            state_q <= StHeader;
                        end
                    end
                end
                StHeader: begin
                    if (hdr_go) begin
                        if (hdr_idx_q == 2'd2) begin
                            hdr_idx_q  <= '0;
                            acq_done_q <= 1'b1;
                            state_q    <= StIdle;
                            // A register load in the same cycle takes priority.
                            if (!trig_num_we_i) begin
                                trig_num_q <= trig_num_q + 32'd1;
                            end
                        end else begin
                            hdr_idx_q <= hdr_idx_q + 2'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The strobe is gated by the live full flag so a word is never offered to a full FIFO;
    // the word itself is held in registers until it is accepted.
    assign header_fifo_wr_en_o = hdr_go;
    assign header_fifo_din_o   = (state_q == StHeader) ? hdr_word : '0;
    assign current_trig_num_o  = trig_num_q;
    assign mem_wea_o           = mem_wea_q;
    assign mem_addra_o         = mem_addra_q;
    assign mem_dina_o          = mem_dina_q;
    assign acq_busy_o          = (state_q != StIdle);
    assign acq_done_o          = acq_done_q;

endmodule

// File: tb/tb_adc_acq_controller.sv
// Testbench for adc_acq_controller: directed timing sequences, a vector table of ring
// geometries, and randomized events checked against a transaction-level model.
module tb_adc_acq_controller;

    logic        clk;
    logic        reset_n;
    logic        arm;
    logic        trig;
    logic        adc_valid;
    logic [31:0] adc_data;
    logic [31:0] buffer_size;
    logic [31:0] post_trig_size;
    logic [31:0] channel_num;
    logic [31:0] initial_trig_num;
    logic        trig_num_we;
    logic        header_fifo_full;
    logic [31:0] current_trig_num;
    logic        mem_wea;
    logic [11:0] mem_addra;
    logic [31:0] mem_dina;
    logic        header_fifo_wr_en;
    logic [31:0] header_fifo_din;
    logic        acq_busy;
    logic        acq_done;

    int checks = 0;
    int errors = 0;

    // Model of the event counter.
    logic [31:0] tn_m;

    // Observed traffic, appended by the monitor only.
    logic [11:0] wr_addr_log[$];
    logic [31:0] wr_data_log[$];
    logic [31:0] hdr_log[$];
    int          done_cnt  = 0;
    int          full_viol = 0;

    typedef struct {
        logic [31:0] bs;
        logic [31:0] pts;
        int          pre;
        logic [31:0] exp_w2;
    } vec_t;

    vec_t vecs[6];

    adc_acq_controller #(
        .ADDR_W    (12),
        .MAX_WORDS (4095)
    ) dut (
        .clk_i               (clk),
        .reset_n_i           (reset_n),
        .arm_i               (arm),
        .trig_i              (trig),
        .adc_valid_i         (adc_valid),
        .adc_data_i          (adc_data),
        .buffer_size_i       (buffer_size),
        .post_trig_size_i    (post_trig_size),
        .channel_num_i       (channel_num),
        .initial_trig_num_i  (initial_trig_num),
        .trig_num_we_i       (trig_num_we),
        .header_fifo_full_i  (header_fifo_full),
        .current_trig_num_o  (current_trig_num),
        .mem_wea_o           (mem_wea),
        .mem_addra_o         (mem_addra),
        .mem_dina_o          (mem_dina),
        .header_fifo_wr_en_o (header_fifo_wr_en),
        .header_fifo_din_o   (header_fifo_din),
        .acq_busy_o          (acq_busy),
        .acq_done_o          (acq_done)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    // Monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mem_wea) begin
            wr_addr_log.push_back(mem_addra);
            wr_data_log.push_back(mem_dina);
        end
        if (header_fifo_wr_en) begin
            hdr_log.push_back(header_fifo_din);
            if (header_fifo_full) full_viol++;
        end
        if (acq_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One full acquisition; expected memory traffic and header derived from the rules:
    // stored words are the valid words after arm up to and including trig, then the first
    // pts valid words after trig; word i goes to address i mod L.
    task automatic run_event(input logic [31:0] bs, input logic [31:0] pts,
                             input logic [31:0] chan, input int pre, input int vpct,
                             input int fpct, input bit noise, input string tag,
                             output logic [31:0] w2_act);
        logic [31:0] exp_d[$];
        logic [31:0] d;
        logic [31:0] w0, w1, w2;
        int          len, n, wbase, hbase, dbase, post_seen, bad, fill, last;
        bit          v, done;
        len   = (bs > 32'd4095) ? 4095 : ((bs == 32'd0) ? 1 : int'(bs));
        wbase = wr_data_log.size();
        hbase = hdr_log.size();
        dbase = done_cnt;
        buffer_size      = bs;
        post_trig_size   = pts;
        channel_num      = chan;
        header_fifo_full = 1'b0;
        arm       = 1'b1;
        adc_valid = noise ? 1'($urandom_range(1)) : 1'b0;
        adc_data  = $urandom;
        tick();
        arm = 1'b0;
        if (noise) buffer_size = $urandom;
        for (int c = 0; c <= pre; c++) begin
            v = ($urandom_range(99) < vpct);
            d = $urandom;
            adc_valid = v;
            adc_data  = d;
            trig      = (c == pre);
            arm       = noise && ($urandom_range(9) == 0);
            if (v) exp_d.push_back(d);
            tick();
        end
        trig = 1'b0;
        arm  = 1'b0;
        if (noise) begin
            post_trig_size = $urandom;
            channel_num    = $urandom;
        end
        post_seen = 0;
        done      = 1'b0;
        for (int b = 0; b < 2000 && !done; b++) begin
            if (acq_done) begin
                done = 1'b1;
            end else begin
                v = ($urandom_range(99) < vpct);
                d = $urandom;
                adc_valid        = v;
                adc_data         = d;
                header_fifo_full = ($urandom_range(99) < fpct);
                trig             = noise && ($urandom_range(7) == 0);
                arm              = noise && ($urandom_range(7) == 0);
                if (v && (post_seen < int'(pts))) begin
                    exp_d.push_back(d);
                    post_seen++;
                end
                tick();
            end
        end
        adc_valid        = 1'b0;
        trig             = 1'b0;
        arm              = 1'b0;
        header_fifo_full = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        tick();
        tick();
        n = exp_d.size();
        check({tag, "_wcount"}, 32'(wr_data_log.size() - wbase), 32'(n));
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (wbase + i >= wr_data_log.size()) bad++;
            else if (wr_addr_log[wbase + i] !== 12'(i % len) ||
                     wr_data_log[wbase + i] !== exp_d[i]) bad++;
        end
        check({tag, "_wbad"}, 32'(bad), 32'd0);
        check({tag, "_hcount"}, 32'(hdr_log.size() - hbase), 32'd3);
        w0 = (hdr_log.size() > hbase)     ? hdr_log[hbase]     : 32'hxxxx_xxxx;
        w1 = (hdr_log.size() > hbase + 1) ? hdr_log[hbase + 1] : 32'hxxxx_xxxx;
        w2 = (hdr_log.size() > hbase + 2) ? hdr_log[hbase + 2] : 32'hxxxx_xxxx;
        fill = (n < len) ? n : len;
        last = (n == 0) ? 0 : (n - 1) % len;
        check({tag, "_w0"}, w0, chan);
        check({tag, "_w1"}, w1, tn_m);
        check({tag, "_w2"}, w2, {8'h00, 12'(fill), 12'(last)});
        check({tag, "_done_cnt"}, 32'(done_cnt - dbase), 32'd1);
        tn_m = tn_m + 32'd1;
        check({tag, "_trig_num"}, current_trig_num, tn_m);
        w2_act = w2;
    endtask

    initial begin
        logic [31:0] w2r;
        int          wb, hb;

        vecs[0] = '{bs: 32'd8,      pts: 32'd3, pre: 4,    exp_w2: 32'h0000_8007};
        vecs[1] = '{bs: 32'd4,      pts: 32'd0, pre: 9,    exp_w2: 32'h0000_4001};
        vecs[2] = '{bs: 32'd0,      pts: 32'd2, pre: 2,    exp_w2: 32'h0000_1000};
        vecs[3] = '{bs: 32'h0000_FFFF, pts: 32'd1, pre: 4094, exp_w2: 32'h00FF_F000};
        vecs[4] = '{bs: 32'd5,      pts: 32'd7, pre: 0,    exp_w2: 32'h0000_5002};
        vecs[5] = '{bs: 32'd3,      pts: 32'd2, pre: 1,    exp_w2: 32'h0000_3000};

        reset_n = 1'b0; arm = 1'b0; trig = 1'b0; adc_valid = 1'b0; adc_data = '0;
        buffer_size = '0; post_trig_size = '0; channel_num = '0; initial_trig_num = '0;
        trig_num_we = 1'b0; header_fifo_full = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Reset state.
        check("rst_mem_wea", 32'(mem_wea), 32'd0);
        check("rst_mem_addra", 32'(mem_addra), 32'd0);
        check("rst_mem_dina", mem_dina, 32'd0);
        check("rst_fifo_wr_en", 32'(header_fifo_wr_en), 32'd0);
        check("rst_fifo_din", header_fifo_din, 32'd0);
        check("rst_busy", 32'(acq_busy), 32'd0);
        check("rst_done", 32'(acq_done), 32'd0);
        check("rst_trig_num", current_trig_num, 32'd0);

        // Counter load and single-word event with cycle-level timing.
        trig_num_we = 1'b1; initial_trig_num = 32'h10;
        tick();
        trig_num_we = 1'b0;
        check("load_trig_num", current_trig_num, 32'h10);
        tn_m = 32'h10;
        buffer_size = 32'd8; arm = 1'b1;
        tick();
        arm = 1'b0;
        check("arm_busy", 32'(acq_busy), 32'd1);
        adc_valid = 1'b1; adc_data = 32'hA5A5_0001;
        tick();
        adc_valid = 1'b0;
        check("lat_wea", 32'(mem_wea), 32'd1);
        check("lat_addr", 32'(mem_addra), 32'd0);
        check("lat_data", mem_dina, 32'hA5A5_0001);
        channel_num = 32'hC0DE_0003; post_trig_size = 32'd0; trig = 1'b1;
        tick();
        trig = 1'b0;
        check("lat_wea_off", 32'(mem_wea), 32'd0);
        check("hdr_next_cycle", 32'(header_fifo_wr_en), 32'd1);
        check("hdr_w0", header_fifo_din, 32'hC0DE_0003);
        tick();
        check("hdr_w1", header_fifo_din, 32'h10);
        tick();
        check("hdr_w2", header_fifo_din, 32'h0000_1000);
        tick();
        check("done_pulse", 32'(acq_done), 32'd1);
        check("done_idle", 32'(acq_busy), 32'd0);
        check("done_trig_num", current_trig_num, 32'h11);
        tn_m = 32'h11;
        tick();
        check("done_one_cycle", 32'(acq_done), 32'd0);

        // Ring geometry table.
        for (int i = 0; i < 6; i++) begin
            run_event(vecs[i].bs, vecs[i].pts, 32'h0000_0100 + 32'(i), vecs[i].pre, 100, 0,
                      1'b0, $sformatf("vec%0d", i), w2r);
            check($sformatf("vec%0d_w2_table", i), w2r, vecs[i].exp_w2);
        end

        // FIFO back-pressure on entry to the header phase.
        buffer_size = 32'd4; arm = 1'b1;
        tick();
        arm = 1'b0;
        adc_valid = 1'b1; adc_data = 32'h1111_0000;
        tick();
        adc_data = 32'h1111_0001;
        tick();
        adc_valid = 1'b0;
        channel_num = 32'hBEEF_0007; post_trig_size = 32'd0; trig = 1'b1;
        header_fifo_full = 1'b1;
        tick();
        trig = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_no_wr_%0d", k), 32'(header_fifo_wr_en), 32'd0);
            check($sformatf("bp_busy_%0d", k), 32'(acq_busy), 32'd1);
            check($sformatf("bp_hold_%0d", k), header_fifo_din, 32'hBEEF_0007);
            tick();
        end
        header_fifo_full = 1'b0;
        #0;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_w;
            exp_w = (k == 0) ? 32'hBEEF_0007 : ((k == 1) ? tn_m : 32'h0000_2001);
            check($sformatf("bp_busy_rel_%0d", k), 32'(acq_busy), 32'd1);
            check($sformatf("bp_wr_%0d", k), 32'(header_fifo_wr_en), 32'd1);
            check($sformatf("bp_word_%0d", k), header_fifo_din, exp_w);
            tick();
        end
        check("bp_done", 32'(acq_done), 32'd1);
        tn_m = tn_m + 32'd1;
        check("bp_trig_num", current_trig_num, tn_m);

        // Counter wrap at 32 bits.
        trig_num_we = 1'b1; initial_trig_num = 32'hFFFF_FFFF;
        tick();
        trig_num_we = 1'b0;
        tn_m = 32'hFFFF_FFFF;
        run_event(32'd6, 32'd1, 32'h0000_0200, 2, 100, 0, 1'b0, "cwrap", w2r);
        check("cwrap_zero", current_trig_num, 32'd0);

        // Load in the W2 cycle beats the increment.
        buffer_size = 32'd4; arm = 1'b1;
        tick();
        arm = 1'b0;
        adc_valid = 1'b1; adc_data = 32'h2222_0000; channel_num = 32'h0000_0300;
        post_trig_size = 32'd0; trig = 1'b1;
        tick();
        adc_valid = 1'b0; trig = 1'b0;
        tick();
        tick();
        check("ld_w2_cycle", header_fifo_din, 32'h0000_1000);
        trig_num_we = 1'b1; initial_trig_num = 32'd5;
        tick();
        trig_num_we = 1'b0;
        check("ld_done", 32'(acq_done), 32'd1);
        check("ld_wins", current_trig_num, 32'd5);
        tn_m = 32'd5;

        // Reset during POST aborts without a header.
        buffer_size = 32'd8; arm = 1'b1;
        tick();
        arm = 1'b0;
        adc_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            adc_data = 32'h3333_0000 + 32'(k);
            trig = (k == 2);
            post_trig_size = 32'd10;
            tick();
        end
        trig = 1'b0;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        adc_valid = 1'b0;
        check("abort_wea", 32'(mem_wea), 32'd0);
        check("abort_addr", 32'(mem_addra), 32'd0);
        check("abort_busy", 32'(acq_busy), 32'd0);
        check("abort_fifo_wr", 32'(header_fifo_wr_en), 32'd0);
        check("abort_trig_num", current_trig_num, 32'd0);
        tn_m = 32'd0;
        wb = wr_data_log.size();
        hb = hdr_log.size();
        adc_valid = 1'b1;
        for (int k = 0; k < 15; k++) tick();
        adc_valid = 1'b0;
        tick();
        check("abort_no_hdr", 32'(hdr_log.size() - hb), 32'd0);
        check("abort_no_wr", 32'(wr_data_log.size() - wb), 32'd0);

        // Trigger while idle is ignored.
        wb = wr_data_log.size();
        trig = 1'b1; adc_valid = 1'b1;
        tick();
        trig = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        adc_valid = 1'b0;
        tick();
        check("idle_trig_busy", 32'(acq_busy), 32'd0);
        check("idle_trig_no_wr", 32'(wr_data_log.size() - wb), 32'd0);

        // Randomized events with gaps, back-pressure, stray arm/trig and register churn.
        for (int e = 0; e < 25; e++) begin
            logic [31:0] bs;
            bs = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(12));
            run_event(bs, 32'($urandom_range(6)), $urandom, int'($urandom_range(15)), 60, 40,
                      1'b1, $sformatf("rnd%0d", e), w2r);
        end

        check("no_strobe_while_full", 32'(full_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
